// File: rtl/frame_shift_engine_if.sv
// Bus bundle for frame_shift_engine: load/shift controls, data paths and status.
// parity_out exists only when SHIFT_PARITY_EN is defined.
interface frame_shift_engine_if #(
  parameter int DEPTH = 8,
  parameter int LEN_W = 4
);
  logic             ld_en;
  logic             shift_en;
  logic             lsb_first;
  logic [LEN_W-1:0] frame_len;
  logic             serial_in;
  logic [DEPTH-1:0] parallel_in;
  logic [DEPTH-1:0] parallel_out;
  logic             serial_out;
  logic             busy;
  logic             done;
`ifdef SHIFT_PARITY_EN
  logic             parity_out;
`endif

  // Handshake: ld_en is always accepted, with no ready, and wins over shift_en.
  // busy rises the cycle after a load. shift_en counts only while busy.
  // done pulses for one cycle on the same edge where busy falls.
`ifdef SHIFT_PARITY_EN
  modport master (
    output ld_en, shift_en, lsb_first, frame_len, serial_in, parallel_in,
    input  parallel_out, serial_out, busy, done, parity_out
  );
  modport slave (
    input  ld_en, shift_en, lsb_first, frame_len, serial_in, parallel_in,
    output parallel_out, serial_out, busy, done, parity_out
  );
`else
  modport master (
    output ld_en, shift_en, lsb_first, frame_len, serial_in, parallel_in,
    input  parallel_out, serial_out, busy, done
  );
  modport slave (
    input  ld_en, shift_en, lsb_first, frame_len, serial_in, parallel_in,
    output parallel_out, serial_out, busy, done
  );
`endif
endinterface

// File: rtl/frame_shift_engine.sv
// Runtime-length, runtime-direction load/shift register for the UART TX/RX datapaths.
// The optional even-parity output is enabled by defining SHIFT_PARITY_EN.
module frame_shift_engine #(
    parameter int DEPTH    = 8,
    parameter int LEN_W    = 4,
    parameter bit IDLE_LVL = 1'b1
) (
    input logic clk,
    input logic rst_n,
    frame_shift_engine_if.slave bus
);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state_q, state_d;
    logic [DEPTH-1:0] reg_q, reg_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             lsb_q, lsb_d;
    logic             done_q, done_d;

    logic [LEN_W-1:0] ld_len;
    logic [DEPTH-1:0] ld_mask;
    logic [DEPTH-1:0] cur_mask;
    logic [DEPTH-1:0] top_bit;
    logic [DEPTH-1:0] shifted;

    // A length of zero, or one longer than the register, means a full-width frame.
    always_comb begin
        ld_len = bus.frame_len;
        if (bus.frame_len == '0 || int'(bus.frame_len) > DEPTH) begin
            ld_len = LEN_W'(DEPTH);
        end
    end

    assign ld_mask  = ~({DEPTH{1'b1}} << ld_len);
    assign cur_mask = ~({DEPTH{1'b1}} << len_q);
    assign top_bit  = DEPTH'(1) << (len_q - LEN_W'(1));

    // Bits at and above L are always zero, so a plain shift plus masking
    // keeps the frame confined to reg[L-1:0].
    always_comb begin
        if (lsb_q) begin
            shifted = (reg_q >> 1) | (bus.serial_in ? top_bit : '0);
        end else begin
            shifted = ((reg_q << 1) | DEPTH'(bus.serial_in)) & cur_mask;
        end
    end

    always_comb begin
        state_d = state_q;
        reg_d   = reg_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        lsb_d   = lsb_q;
        done_d  = 1'b0;
        if (bus.ld_en) begin
            reg_d   = bus.parallel_in & ld_mask;
            cnt_d   = ld_len;
            len_d   = ld_len;
            lsb_d   = bus.lsb_first;
            state_d = SHIFT;
        end else if (state_q == SHIFT && bus.shift_en) begin
            reg_d = shifted;
            cnt_d = cnt_q - LEN_W'(1);
            if (cnt_q == LEN_W'(1)) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            reg_q   <= '0;
            cnt_q   <= '0;
            len_q   <= LEN_W'(DEPTH);
            lsb_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            reg_q   <= reg_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            lsb_q   <= lsb_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy         = (state_q == SHIFT);
    assign bus.done         = done_q;
    assign bus.parallel_out = reg_q;
    assign bus.serial_out   = (state_q == SHIFT) ? (lsb_q ? reg_q[0] : |(reg_q & top_bit))
                                                 : IDLE_LVL;
`ifdef SHIFT_PARITY_EN
    assign bus.parity_out   = ^reg_q;
`endif

endmodule

// File: doc/frame_shift_engine.md
Name: frame_shift_engine

Overview:
- Parametrised successor to the team's fixed-width load/shift register, used as the datapath core of the UART TX and RX paths.
- Adds a runtime frame length, runtime MSB-first or LSB-first direction, an internal bit counter, and busy/done handshakes.
- Drives an idle line level between frames.
- One instance serialises a TX word; a second instance, loaded with zeros, deserialises an RX frame.

Parameters:
- DEPTH, 8: physical register width and maximum frame length in bits (must be at least 2).
- LEN_W, 4: width of frame_len. Must hold the value DEPTH.
- IDLE_LVL, 1: serial_out level while not busy. 1 matches the UART mark state.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ld_en  in  1  load request: starts a frame.
- shift_en  in  1  shift strobe, one bit per assertion (normally the baud tick).
- lsb_first  in  1  1 = shift toward bit 0, LSB out first; 0 = MSB-first. Sampled on load.
- frame_len  in  LEN_W  bits per frame. Sampled on load.
- serial_in  in  1  serial data in.
- parallel_in  in  DEPTH  parallel load word.
- parallel_out  out  DEPTH  register contents; bits at or above the latched length read 0.
- serial_out  out  1  current output bit, or IDLE_LVL when not busy.
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse at frame end.

Behaviour:
- Reset: the asynchronous assertion of rst_n clears the register, counter, done and busy. The latched length becomes DEPTH and latched lsb_first becomes 0. serial_out = IDLE_LVL, parallel_out = 0.
- Length latch:
  - frame_len = 0 is latched as DEPTH.
  - frame_len > DEPTH is clamped to DEPTH.
  - The latched value is called L.
- States: IDLE (busy = 0) and SHIFT (busy = 1). busy is a registered output.
- Load (ld_en = 1, any state):
  - reg <= parallel_in with bits [DEPTH-1:L] zeroed.
  - cnt <= L; latch L and lsb_first; go to SHIFT.
  - ld_en has priority over shift_en in the same cycle. A load during SHIFT aborts the current frame with no done pulse.
- Shift (SHIFT, ld_en = 0, shift_en = 1):
  - MSB-first: reg[L-1:0] <= {reg[L-2:0], serial_in}.
  - LSB-first: reg[L-1:0] <= {serial_in, reg[L-1:1]}.
  - cnt <= cnt - 1.
  - If cnt == 1 before the edge: go to IDLE and set done = 1 for exactly the next cycle.
- shift_en in IDLE is ignored. The register holds, so the received word stays readable.
- serial_out:
  - While busy: reg[L-1] when MSB-first, reg[0] when LSB-first.
  - Otherwise: IDLE_LVL.
  - The first data bit appears in the cycle after load. Each subsequent bit appears in the cycle after each accepted shift.
- RX usage: load zeros, then apply L shifts.
  - LSB-first: the first received bit ends at parallel_out[0].
  - MSB-first: the first received bit ends at parallel_out[L-1].
  - The word is valid when done is asserted.
- Latency: load to busy = 1 cycle. The final shift edge to done = 1 and busy = 0 happen on the same edge.
- L = 1 (register-edge case): a single shift completes the frame.
- Reset mid-frame: the block returns immediately to the reset state; no done pulse.

Optional Feature:
- Macro: SHIFT_PARITY_EN.
- With the macro defined:
  - Adds output parity_out (1 bit) = XOR of reg[L-1:0], combinational from the register.
  - On TX it is the even-parity bit of the loaded word. On RX it checks the received word when done = 1.
  - Reset value 0.
- Without it: the port and logic are absent, and the remaining behaviour is unchanged.

Test Plan:
- Reset, hold rst_n low for 3 cycles, release -> serial_out = 1, busy = 0, done = 0, parallel_out = 0x00.
- Load parallel_in = 0xA5, frame_len = 8, lsb_first = 0; pulse shift_en 8 times -> serial_out sequence 1,0,1,0,0,1,0,1; done high for 1 cycle after the 8th shift; then busy = 0 and serial_out = 1.
- Load 0x00, frame_len = 5, lsb_first = 1; shift in serial_in = 1,1,0,1,0 -> parallel_out = 0x0B at done; bits [7:5] = 0; one further shift_en leaves parallel_out unchanged.
- Load 0xFF with frame_len = 12 (clamped to 8), apply 3 shifts, then load 0x0F with frame_len = 4, lsb_first = 1 in the same cycle as a shift_en -> no done pulse; reload wins; serial_out = 1,1,1,1 then done.
- Load with frame_len = 0 -> exactly 8 shifts required for done. Assert rst_n low after 4 shifts -> busy = 0, serial_out = 1, no done pulse.
- SHIFT_PARITY_EN defined: load 0xA5 with L = 8 -> parity_out = 0; load 0x07 with L = 3 -> parity_out = 1.
